// File: rtl/frame_rate_mon_pkg.sv
// frame_rate_mon_pkg: shared state encoding and counter helpers for the
// frame-rate monitor and its per-channel sub-module.
package frame_rate_mon_pkg;

   // Per-channel monitor state
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_STALL = 2'd3
   } fr_state_t;

   // All-ones saturation value for a counter of the given width
   function automatic logic [63:0] cnt_sat_value(input int unsigned width);
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/frame_rate_mon_ch.sv
// frame_rate_mon_ch: one monitored channel. Resynchronises an asynchronous
// frame strobe, detects its rising edge, measures the frame period in clk
// cycles, counts frames and flags a stalled source.
// Optional min/max period tracking is built when FRAME_RATE_MON_MINMAX_EN
// is defined; otherwise period_min/period_max are tied to 0.
module frame_rate_mon_ch #(
   parameter int CNT_WIDTH   = 27,
   parameter int FCNT_WIDTH  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 5_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trig,
   input  logic                  clr,
   output logic                  tick,
   output logic [CNT_WIDTH-1:0]  period,
   output logic                  period_valid,
   output logic [FCNT_WIDTH-1:0] frame_cnt,
   output logic                  stall,
   output logic [CNT_WIDTH-1:0]  period_min,
   output logic [CNT_WIDTH-1:0]  period_max
);

   import frame_rate_mon_pkg::*;

   localparam logic [CNT_WIDTH-1:0]  CNT_SAT     = CNT_WIDTH'(cnt_sat_value(CNT_WIDTH));
   localparam logic [CNT_WIDTH-1:0]  CNT_TO_LAST = CNT_WIDTH'(TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);
   localparam logic [FCNT_WIDTH-1:0] FCNT_ONE    = FCNT_WIDTH'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   edge_prev_q, edge_prev_d;
   logic                   edge_det;
   logic                   tick_q, tick_d;
   fr_state_t              state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]   meas_val;
   logic [CNT_WIDTH-1:0]   period_q, period_d;
   logic                   period_valid_q, period_valid_d;
   logic [FCNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
   logic                   stall_q, stall_d;

   assign edge_det = sync_q[SYNC_STAGES-1] & ~edge_prev_q;
   assign meas_val = cnt_q + CNT_ONE;

   // Shift the strobe through the synchroniser and remember the last synced level
   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], trig};
      edge_prev_d = sync_q[SYNC_STAGES-1];
   end

   // Next-state, counters and measurement; clr overrides everything at the end
   always_comb begin
      state_d        = state_q;
      cnt_d          = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
      period_d       = period_q;
      period_valid_d = period_valid_q;
      frame_cnt_d    = frame_cnt_q;
      tick_d         = edge_det & ~clr;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (edge_det) begin
               state_d     = ST_ARMED;
               frame_cnt_d = frame_cnt_q + FCNT_ONE;
            end
         end
         ST_ARMED: begin
            if (edge_det) begin
               state_d        = ST_RUN;
               cnt_d          = '0;
               period_d       = meas_val;
               period_valid_d = 1'b1;
               frame_cnt_d    = frame_cnt_q + FCNT_ONE;
            end else if (cnt_q == CNT_TO_LAST) begin
               state_d = ST_STALL;
            end
         end
         ST_RUN: begin
            if (edge_det) begin
               cnt_d       = '0;
               period_d    = meas_val;
               frame_cnt_d = frame_cnt_q + FCNT_ONE;
            end else if (cnt_q == CNT_TO_LAST) begin
               state_d = ST_STALL;
            end
         end
         ST_STALL: begin
            if (edge_det) begin
               state_d        = ST_ARMED;
               cnt_d          = '0;
               period_valid_d = 1'b0;
               frame_cnt_d    = frame_cnt_q + FCNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (clr) begin
         state_d        = ST_IDLE;
         cnt_d          = '0;
         period_d       = '0;
         period_valid_d = 1'b0;
         frame_cnt_d    = '0;
      end

      stall_d = (state_d == ST_STALL);
   end

   // Channel state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q         <= '0;
         edge_prev_q    <= 1'b0;
         tick_q         <= 1'b0;
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         frame_cnt_q    <= '0;
         stall_q        <= 1'b0;
      end else begin
         sync_q         <= sync_d;
         edge_prev_q    <= edge_prev_d;
         tick_q         <= tick_d;
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         frame_cnt_q    <= frame_cnt_d;
         stall_q        <= stall_d;
      end
   end

   assign tick         = tick_q;
   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign frame_cnt    = frame_cnt_q;
   assign stall        = stall_q;

`ifdef FRAME_RATE_MON_MINMAX_EN
   logic                 meas;
   logic [CNT_WIDTH-1:0] period_min_q, period_min_d;
   logic [CNT_WIDTH-1:0] period_max_q, period_max_d;
   logic                 mm_loaded_q, mm_loaded_d;

   assign meas = edge_det & ~clr & ((state_q == ST_ARMED) || (state_q == ST_RUN));

   // Track extremes of valid measurements; the first one seeds both, stalls leave them alone
   always_comb begin
      period_min_d = period_min_q;
      period_max_d = period_max_q;
      mm_loaded_d  = mm_loaded_q;
      if (clr) begin
         period_min_d = '0;
         period_max_d = '0;
         mm_loaded_d  = 1'b0;
      end else if (meas) begin
         mm_loaded_d = 1'b1;
         if (!mm_loaded_q) begin
            period_min_d = meas_val;
            period_max_d = meas_val;
         end else begin
            if (meas_val < period_min_q) period_min_d = meas_val;
            if (meas_val > period_max_q) period_max_d = meas_val;
         end
      end
   end

   // Min/max registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_min_q <= '0;
         period_max_q <= '0;
         mm_loaded_q  <= 1'b0;
      end else begin
         period_min_q <= period_min_d;
         period_max_q <= period_max_d;
         mm_loaded_q  <= mm_loaded_d;
      end
   end

   assign period_min = period_min_q;
   assign period_max = period_max_q;
`else
   assign period_min = '0;
   assign period_max = '0;
`endif

endmodule

// File: rtl/frame_rate_mon.sv
// frame_rate_mon: N-channel frame-timing monitor. Instantiates one
// frame_rate_mon_ch per strobe, packs the per-channel results (ch0 in the
// LSBs) and registers the OR of all stall flags.
// Define FRAME_RATE_MON_MINMAX_EN to build per-channel min/max period tracking.
module frame_rate_mon #(
   parameter int N_CH        = 2,
   parameter int CNT_WIDTH   = 27,
   parameter int FCNT_WIDTH  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 5_000_000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_CH-1:0]            trig,
   input  logic                       clr,
   output logic [N_CH-1:0]            tick,
   output logic [N_CH*CNT_WIDTH-1:0]  period,
   output logic [N_CH-1:0]            period_valid,
   output logic [N_CH*FCNT_WIDTH-1:0] frame_cnt,
   output logic [N_CH-1:0]            stall,
   output logic                       any_stall,
   output logic [N_CH*CNT_WIDTH-1:0]  period_min,
   output logic [N_CH*CNT_WIDTH-1:0]  period_max
);

   import frame_rate_mon_pkg::*;

   logic any_stall_q, any_stall_d;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      frame_rate_mon_ch #(
         .CNT_WIDTH   (CNT_WIDTH),
         .FCNT_WIDTH  (FCNT_WIDTH),
         .SYNC_STAGES (SYNC_STAGES),
         .TIMEOUT     (TIMEOUT)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .trig         (trig[i]),
         .clr          (clr),
         .tick         (tick[i]),
         .period       (period[i*CNT_WIDTH +: CNT_WIDTH]),
         .period_valid (period_valid[i]),
         .frame_cnt    (frame_cnt[i*FCNT_WIDTH +: FCNT_WIDTH]),
         .stall        (stall[i]),
         .period_min   (period_min[i*CNT_WIDTH +: CNT_WIDTH]),
         .period_max   (period_max[i*CNT_WIDTH +: CNT_WIDTH])
      );
   end

   // OR of the stall flags, forced low by clr so every output is 0 right after a clear
   always_comb begin
      any_stall_d = clr ? 1'b0 : |stall;
   end

   // Summary stall register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) any_stall_q <= 1'b0;
      else     any_stall_q <= any_stall_d;
   end

   assign any_stall = any_stall_q;

endmodule

// File: tb/tb_frame_rate_mon.sv
// tb_frame_rate_mon: directed self-checking bench for frame_rate_mon.
// Runs with N_CH=2, FCNT_WIDTH=4, TIMEOUT=1000; expectations for the
// min/max ports follow whether FRAME_RATE_MON_MINMAX_EN is defined.
module tb_frame_rate_mon;

   localparam int N_CH        = 2;
   localparam int CNT_WIDTH   = 27;
   localparam int FCNT_WIDTH  = 4;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = 1000;
`ifdef FRAME_RATE_MON_MINMAX_EN
   localparam bit MM_EN = 1'b1;
`else
   localparam bit MM_EN = 1'b0;
`endif

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       clr;
   logic [N_CH-1:0]            trig;
   logic [N_CH-1:0]            tick;
   logic [N_CH*CNT_WIDTH-1:0]  period;
   logic [N_CH-1:0]            period_valid;
   logic [N_CH*FCNT_WIDTH-1:0] frame_cnt;
   logic [N_CH-1:0]            stall;
   logic                       any_stall;
   logic [N_CH*CNT_WIDTH-1:0]  period_min;
   logic [N_CH*CNT_WIDTH-1:0]  period_max;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit ch1_auto = 1'b0;
   int ch1_base = 0;

   frame_rate_mon #(
      .N_CH        (N_CH),
      .CNT_WIDTH   (CNT_WIDTH),
      .FCNT_WIDTH  (FCNT_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .trig         (trig),
      .clr          (clr),
      .tick         (tick),
      .period       (period),
      .period_valid (period_valid),
      .frame_cnt    (frame_cnt),
      .stall        (stall),
      .any_stall    (any_stall),
      .period_min   (period_min),
      .period_max   (period_max)
   );

   // 10 time-unit clock
   always #5 clk = ~clk;

   function automatic logic [63:0] per(input int ch);
      return 64'(period[ch*CNT_WIDTH +: CNT_WIDTH]);
   endfunction

   function automatic logic [63:0] fcnt(input int ch);
      return 64'(frame_cnt[ch*FCNT_WIDTH +: FCNT_WIDTH]);
   endfunction

   function automatic logic [63:0] pmin(input int ch);
      return 64'(period_min[ch*CNT_WIDTH +: CNT_WIDTH]);
   endfunction

   function automatic logic [63:0] pmax(input int ch);
      return 64'(period_max[ch*CNT_WIDTH +: CNT_WIDTH]);
   endfunction

   // Advance n clocks, landing 1 unit after each rising edge; also runs the
   // background 100-cycle strobe on ch1 when enabled
   task automatic stepCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (ch1_auto) begin
            if ((cyc - ch1_base) % 100 == 0)       trig[1] = 1'b1;
            else if ((cyc - ch1_base) % 100 == 10) trig[1] = 1'b0;
         end
      end
   endtask

   // One strobe on channel ch: high for 5 cycles, next rise gap cycles later
   task automatic applyStimulus(input int ch, input int gap);
      trig[ch] = 1'b1;
      stepCycles(5);
      trig[ch] = 1'b0;
      stepCycles(gap - 5);
   endtask

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   initial begin
      rst  = 1'b1;
      clr  = 1'b0;
      trig = '0;
      stepCycles(3);

      // Everything is zero while reset is held
      checkOutput("rst_tick",   64'(tick), 0);
      checkOutput("rst_period", 64'(period), 0);
      checkOutput("rst_pvalid", 64'(period_valid), 0);
      checkOutput("rst_fcnt",   64'(frame_cnt), 0);
      checkOutput("rst_stall",  64'(stall), 0);
      checkOutput("rst_any",    64'(any_stall), 0);
      checkOutput("rst_min",    64'(period_min), 0);
      checkOutput("rst_max",    64'(period_max), 0);
      rst = 1'b0;
      stepCycles(2);

      // Five ch0 edges 100 cycles apart; tick lands 3 cycles after each rise
      $display("[TB] periodic ch0 strobe");
      for (int e = 1; e <= 5; e++) begin
         trig[0] = 1'b1;
         stepCycles(2);
         checkOutput("t1_tick_early", 64'(tick[0]), 0);
         stepCycles(1);
         checkOutput("t1_tick", 64'(tick[0]), 1);
         checkOutput("t1_fcnt", fcnt(0), 64'(e));
         checkOutput("t1_pvalid", 64'(period_valid[0]), (e >= 2) ? 1 : 0);
         if (e >= 2) checkOutput("t1_period", per(0), 100);
         stepCycles(1);
         checkOutput("t1_tick_one_cycle", 64'(tick[0]), 0);
         stepCycles(7);
         trig[0] = 1'b0;
         stepCycles(89);
      end
      checkOutput("t1_min", pmin(0), MM_EN ? 100 : 0);
      checkOutput("t1_max", pmax(0), MM_EN ? 100 : 0);

      // ch0 stops after two edges and stalls; ch1 keeps running every 100 cycles
      $display("[TB] ch0 stall with ch1 running");
      rst = 1'b1;
      stepCycles(1);
      rst = 1'b0;
      stepCycles(1);
      trig[1]  = 1'b1;
      ch1_base = cyc;
      ch1_auto = 1'b1;
      trig[0]  = 1'b1;
      stepCycles(3);
      checkOutput("t2_fcnt1", fcnt(0), 1);
      stepCycles(8);
      trig[0] = 1'b0;
      stepCycles(89);
      trig[0] = 1'b1;
      stepCycles(3);
      checkOutput("t2_period", per(0), 100);
      checkOutput("t2_pvalid", 64'(period_valid[0]), 1);
      stepCycles(8);
      trig[0] = 1'b0;
      stepCycles(991);
      checkOutput("t2_stall_before", 64'(stall[0]), 0);
      stepCycles(1);
      checkOutput("t2_stall", 64'(stall[0]), 1);
      checkOutput("t2_any_lag", 64'(any_stall), 0);
      checkOutput("t2_period_hold", per(0), 100);
      checkOutput("t2_pvalid_hold", 64'(period_valid[0]), 1);
      stepCycles(1);
      checkOutput("t2_any", 64'(any_stall), 1);
      checkOutput("t2_ch1_stall", 64'(stall[1]), 0);
      checkOutput("t2_ch1_period", per(1), 100);
      checkOutput("t2_ch1_pvalid", 64'(period_valid[1]), 1);

      // Stalled ch0 restarts with two edges 200 cycles apart
      $display("[TB] ch0 recovery");
      trig[0] = 1'b1;
      stepCycles(3);
      checkOutput("t3_stall_clear", 64'(stall[0]), 0);
      checkOutput("t3_pvalid_clear", 64'(period_valid[0]), 0);
      checkOutput("t3_fcnt", fcnt(0), 3);
      checkOutput("t3_any_lag", 64'(any_stall), 1);
      stepCycles(1);
      checkOutput("t3_any_clear", 64'(any_stall), 0);
      stepCycles(7);
      trig[0] = 1'b0;
      stepCycles(189);
      trig[0] = 1'b1;
      stepCycles(3);
      checkOutput("t3_period", per(0), 200);
      checkOutput("t3_pvalid", 64'(period_valid[0]), 1);
      checkOutput("t3_fcnt4", fcnt(0), 4);
      checkOutput("t3_min", pmin(0), MM_EN ? 100 : 0);
      checkOutput("t3_max", pmax(0), MM_EN ? 200 : 0);
      ch1_auto = 1'b0;
      trig[1]  = 1'b0;

      // clr coincides with the internal edge on ch0
      $display("[TB] clear behaviour");
      stepCycles(5);
      trig[0] = 1'b0;
      stepCycles(20);
      trig[0] = 1'b1;
      stepCycles(2);
      clr = 1'b1;
      stepCycles(1);
      clr = 1'b0;
      checkOutput("t4_tick", 64'(tick), 0);
      checkOutput("t4_period", 64'(period), 0);
      checkOutput("t4_pvalid", 64'(period_valid), 0);
      checkOutput("t4_fcnt", 64'(frame_cnt), 0);
      checkOutput("t4_stall", 64'(stall), 0);
      checkOutput("t4_any", 64'(any_stall), 0);
      checkOutput("t4_min", 64'(period_min), 0);
      checkOutput("t4_max", 64'(period_max), 0);
      stepCycles(1);
      checkOutput("t4_tick_after", 64'(tick[0]), 0);

      // clr held across an edge keeps the channel idle
      stepCycles(5);
      trig[0] = 1'b0;
      stepCycles(5);
      clr     = 1'b1;
      trig[0] = 1'b1;
      stepCycles(3);
      checkOutput("t4_hold_tick", 64'(tick[0]), 0);
      stepCycles(3);
      checkOutput("t4_hold_fcnt", fcnt(0), 0);
      clr = 1'b0;
      stepCycles(1);
      trig[0] = 1'b0;
      stepCycles(5);
      trig[0] = 1'b1;
      stepCycles(3);
      checkOutput("t4_next_tick", 64'(tick[0]), 1);
      checkOutput("t4_next_fcnt", fcnt(0), 1);
      checkOutput("t4_next_pvalid", 64'(period_valid[0]), 0);

      // Edge arrives in the same cycle the timeout would fire: edge wins
      $display("[TB] edge versus timeout");
      stepCycles(8);
      trig[0] = 1'b0;
      stepCycles(989);
      trig[0] = 1'b1;
      stepCycles(2);
      checkOutput("t5_no_stall_pre", 64'(stall[0]), 0);
      stepCycles(1);
      checkOutput("t5_no_stall", 64'(stall[0]), 0);
      checkOutput("t5_pvalid", 64'(period_valid[0]), 1);
      checkOutput("t5_period", per(0), 1000);

      // 4-bit frame counter wraps after 16 frames
      $display("[TB] frame counter wrap");
      stepCycles(5);
      trig[0] = 1'b0;
      stepCycles(2);
      clr = 1'b1;
      stepCycles(1);
      clr = 1'b0;
      stepCycles(1);
      for (int i = 1; i <= 17; i++) begin
         trig[0] = 1'b1;
         stepCycles(3);
         if (i == 15) checkOutput("t6_fcnt15", fcnt(0), 15);
         if (i == 16) checkOutput("t6_fcnt_wrap", fcnt(0), 0);
         stepCycles(2);
         trig[0] = 1'b0;
         stepCycles(5);
      end
      checkOutput("t6_fcnt17", fcnt(0), 1);
      checkOutput("t6_period", per(0), 10);

      // Asynchronous reset between clock edges clears outputs at once
      $display("[TB] async reset");
      #3;
      rst = 1'b1;
      #1;
      checkOutput("t7_period", 64'(period), 0);
      checkOutput("t7_fcnt", 64'(frame_cnt), 0);
      checkOutput("t7_pvalid", 64'(period_valid), 0);
      stepCycles(1);
      rst = 1'b0;
      stepCycles(1);

      // Periods 120, 80, 150 on ch0
      $display("[TB] min/max tracking");
      applyStimulus(0, 120);
      applyStimulus(0, 80);
      applyStimulus(0, 150);
      trig[0] = 1'b1;
      stepCycles(3);
      checkOutput("t8_period", per(0), 150);
      checkOutput("t8_min", pmin(0), MM_EN ? 80 : 0);
      checkOutput("t8_max", pmax(0), MM_EN ? 150 : 0);
      stepCycles(5);
      trig[0] = 1'b0;
      clr = 1'b1;
      stepCycles(1);
      clr = 1'b0;
      checkOutput("t8_min_clr", pmin(0), 0);
      checkOutput("t8_max_clr", pmax(0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
